result_fifo: RTL and testbench

RESULT_FIFO -- requirements
Module: result_fifo

---
 rtl/result_fifo_if.sv | 16 +
 rtl/result_fifo.sv | 71 +++++++
 tb/tb_result_fifo.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/result_fifo_if.sv
// result_fifo_if: push/pop/status bundle between the ALU datapath, the CSR unit and the result FIFO
interface result_fifo_if #(
  parameter int DATA_WIDTH   = 25,
  parameter int STATUS_WIDTH = 25
);
  logic                    w_en;
  logic [DATA_WIDTH-1:0]   w_data;
  logic                    r_en;
  logic                    clr_status;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic [STATUS_WIDTH-1:0] status;
  logic                    empty;
  logic                    full;
  modport master (output w_en, w_data, r_en, clr_status, input rd_data, status, empty, full);
  modport slave  (input w_en, w_data, r_en, clr_status, output rd_data, status, empty, full);
endinterface

// File: rtl/result_fifo.sv
// result_fifo: circular result buffer with registered head word and sticky status; RESULT_FIFO_DROP_CNT_EN enables the drop counter
module result_fifo #(
  parameter int DATA_WIDTH   = 25,
  parameter int DEPTH        = 8,
  parameter int STATUS_WIDTH = 25
) (
  input logic         clk,
  input logic         rst_n,
  result_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt, cnt_nxt;
  logic          ovf, udf, ovf_nxt, udf_nxt;
  logic          do_push, do_pop, ovf_ev, udf_ev, empty_nxt, full_nxt;
  logic [7:0]    drop_nxt;
  logic [18:0]   st_nxt;
  // Accept/reject decisions and the post-edge view of every status field
  always_comb begin
    do_pop    = bus.r_en & ~bus.empty;
    do_push   = bus.w_en & (~bus.full | do_pop);
    ovf_ev    = bus.w_en & ~do_push;
    udf_ev    = bus.r_en & bus.empty;
    wr_nxt    = wr_ptr + PW'(do_push);
    rd_nxt    = rd_ptr + PW'(do_pop);
    cnt_nxt   = wr_nxt - rd_nxt;
    ovf_nxt   = ovf_ev | (ovf & ~bus.clr_status);
    udf_nxt   = udf_ev | (udf & ~bus.clr_status);
    empty_nxt = cnt_nxt == '0;
    full_nxt  = cnt_nxt == PW'(DEPTH);
    st_nxt    = {drop_nxt, udf_nxt, ovf_nxt, full_nxt, empty_nxt, 7'(cnt_nxt)};
  end
`ifdef RESULT_FIFO_DROP_CNT_EN
  logic [7:0] drop;
  // Saturating count of dropped pushes; a drop in the clearing cycle still counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop <= '0;
    else drop <= drop_nxt;
  end
  assign drop_nxt = bus.clr_status ? {7'd0, ovf_ev} : drop + 8'(ovf_ev && drop != 8'hff);
`else
  assign drop_nxt = '0;
`endif
  // Storage array is write-only on push; never reset since pops cannot reach unwritten slots
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= bus.w_data;
  end
  // Pointers, sticky flags and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ovf         <= 1'b0;
      udf         <= 1'b0;
      bus.rd_data <= '0;
      bus.empty   <= 1'b1;
      bus.full    <= 1'b0;
      bus.status  <= STATUS_WIDTH'(19'h80);
    end else begin
      wr_ptr     <= wr_nxt;
      rd_ptr     <= rd_nxt;
      ovf        <= ovf_nxt;
      udf        <= udf_nxt;
      bus.empty  <= empty_nxt;
      bus.full   <= full_nxt;
      bus.status <= STATUS_WIDTH'(st_nxt);
      if (do_pop) bus.rd_data <= mem[rd_ptr[AW-1:0]];
    end
  end
endmodule

// File: tb/tb_result_fifo.sv
// tb_result_fifo: randomized and directed checks of result_fifo against a queue-based model
module tb_result_fifo;
  localparam int DW = 25;
  localparam int DEPTH = 8;
  localparam int SW = 25;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_rd;
  bit ovf, udf;
  int drop;
  always #5 clk = ~clk;
  result_fifo_if #(.DATA_WIDTH(DW), .STATUS_WIDTH(SW)) bus ();
  result_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .STATUS_WIDTH(SW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] exp_status();
    return {13'd0, 8'(drop), udf, ovf, q.size() == DEPTH, q.size() == 0, 7'(q.size())};
  endfunction
  task automatic model_reset();
    q.delete();
    exp_rd = '0;
    ovf = 0;
    udf = 0;
    drop = 0;
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".rd"}, 32'(bus.rd_data), 32'(exp_rd));
    chk({tag, ".status"}, 32'(bus.status), exp_status());
    chk({tag, ".empty"}, 32'(bus.empty), 32'(q.size() == 0));
    chk({tag, ".full"}, 32'(bus.full), 32'(q.size() == DEPTH));
  endtask
  task automatic op(input bit w, input logic [DW-1:0] d, input bit r, input bit c, input string tag);
    bit was_full, was_empty, pop_ok, push_ok, ovf_ev, udf_ev;
    bus.w_en = w;
    bus.w_data = d;
    bus.r_en = r;
    bus.clr_status = c;
    @(posedge clk);
    #1;
    bus.w_en = 0;
    bus.r_en = 0;
    bus.clr_status = 0;
    was_full = q.size() == DEPTH;
    was_empty = q.size() == 0;
    pop_ok = r && !was_empty;
    push_ok = w && (!was_full || pop_ok);
    ovf_ev = w && !push_ok;
    udf_ev = r && was_empty;
    if (pop_ok) exp_rd = q.pop_front();
    if (push_ok) q.push_back(d);
    ovf = ovf_ev || (ovf && !c);
    udf = udf_ev || (udf && !c);
`ifdef RESULT_FIFO_DROP_CNT_EN
    drop = c ? int'(ovf_ev) : (ovf_ev && drop < 255) ? drop + 1 : drop;
`else
    drop = 0;
`endif
    check_all(tag);
  endtask
  task automatic fill();
    while (q.size() < DEPTH) op(1, DW'($urandom), 0, 0, "fill");
  endtask
  task automatic drain();
    while (q.size() > 0) op(0, '0, 1, 0, "drain");
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.w_en = 0;
    bus.w_data = '0;
    bus.r_en = 0;
    bus.clr_status = 0;
    #1 rst_n = 0;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst_n = 1;
    for (int i = 1; i <= 8; i++) op(1, DW'(i), 0, 0, "seq_push");
    chk("seq_full", 32'(bus.full), 32'd1);
    chk("seq_count", 32'(bus.status[6:0]), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      op(0, '0, 1, 0, "seq_pop");
      chk("seq_order", 32'(bus.rd_data), 32'(i));
    end
    chk("seq_empty", 32'(bus.empty), 32'd1);
    fill();
    op(1, 25'h1abcdef, 0, 0, "drop");
    chk("drop_ovf", 32'(bus.status[9]), 32'd1);
`ifdef RESULT_FIFO_DROP_CNT_EN
    chk("drop_cnt", 32'(bus.status[18:11]), 32'd1);
`else
    chk("drop_cnt", 32'(bus.status[18:11]), 32'd0);
`endif
    drain();
    op(0, '0, 0, 1, "clr");
    op(1, 25'h0000aa, 1, 0, "empty_rw");
    chk("empty_rw_cnt", 32'(bus.status[6:0]), 32'd1);
    chk("empty_rw_udf", 32'(bus.status[10]), 32'd1);
    op(0, '0, 1, 0, "empty_rw_pop");
    chk("empty_rw_data", 32'(bus.rd_data), 32'h0000aa);
    op(0, '0, 0, 1, "clr");
    fill();
    repeat (20) op(1, DW'($urandom), 1, 0, "full_rw");
    chk("full_rw_full", 32'(bus.full), 32'd1);
    drain();
    fill();
    op(1, DW'($urandom), 0, 0, "ovf1");
    op(1, DW'($urandom), 0, 1, "ovf_clr");
    chk("ovf_clr_flag", 32'(bus.status[9]), 32'd1);
`ifdef RESULT_FIFO_DROP_CNT_EN
    chk("ovf_clr_cnt", 32'(bus.status[18:11]), 32'd1);
`else
    chk("ovf_clr_cnt", 32'(bus.status[18:11]), 32'd0);
`endif
    op(0, '0, 0, 1, "clr_only");
    chk("clr_only_bits", 32'(bus.status[18:9]), 32'd0);
    drain();
    repeat (400) op($urandom_range(0, 2) != 0, DW'($urandom), $urandom_range(0, 2) != 0,
                    $urandom_range(0, 15) == 0, "rand");
    drain();
    op(0, '0, 0, 1, "clr");
    for (int i = 0; i < 4; i++) op(1, DW'($urandom), 0, 0, "pre_rst");
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("async_empty", 32'(bus.empty), 32'd1);
    chk("async_full", 32'(bus.full), 32'd0);
    chk("async_status", 32'(bus.status), 32'h80);
    chk("async_rd", 32'(bus.rd_data), 32'd0);
    model_reset();
    bus.w_en = 1;
    bus.w_data = 25'h5;
    @(posedge clk);
    #1;
    check_all("in_reset");
    @(negedge clk);
    rst_n = 1;
    op(1, 25'h5, 0, 0, "post_rst");
    op(0, '0, 1, 0, "post_rst_pop");
    chk("post_rst_data", 32'(bus.rd_data), 32'h5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
